out_bank_cell: RTL and testbench
================================

# out_bank_cell

Parametrised multi-channel output cell for the AP3 IO interface. It drives WIDTH pad channels in one of three modes: registered, pass-through buffer, or a new serialiser mode. In serialiser mode a parallel word per channel is shifted out LSB-first under a ready/valid load handshake, with an underrun indication. It sits between fabric logic and the per-pad VPR output pad instances.

## Interface
- WIDTH, 4: number of pad channels; must be ≥ 1.
- MODE, "OUT_REG": "OUT_REG" | "OUT_BUFF" | "OUT_SER". Any other value is an elaboration error.
- SER_RATIO, 4: bits per channel per serial word; must be ≥ 2. Used only in OUT_SER.
- RESET_VAL, 1'b0: pad level driven during and after reset in OUT_REG and OUT_SER.

- IQC  in  1  clock; rising edge.
- QRT  in  1  reset; asynchronous assert, active-low.
- QDI  in  WIDTH  per-channel data for OUT_REG and OUT_BUFF.
- QEN  in  WIDTH  per-channel output enable.
- QPD  in  WIDTH*SER_RATIO  parallel word. Channel c uses QPD[c*SER_RATIO +: SER_RATIO].
- QLD  in  1  load valid for QPD (OUT_SER).
- QRDY  out  1  ready to accept a load (OUT_SER); tied 0 in the other modes.
- QUF  out  1  one-cycle underrun pulse (OUT_SER); tied 0 in the other modes.
- PAD  out  WIDTH  pad data.
- PAD_OE  out  WIDTH  pad output enable.

## Operation
- OUT_BUFF: PAD = QDI and PAD_OE = QEN, purely combinational. Reset has no effect.
- OUT_REG: each edge, PAD <= QDI and PAD_OE <= QEN.
- OUT_SER state machine:
  - States are IDLE and SHIFT. A shared down-counter cnt of width $clog2(SER_RATIO) serves all channels.
  - A load fires on an edge where QLD && QRDY. Each channel's shift register takes its QPD slice, and bit 0 goes to PAD. cnt <= SER_RATIO-1, and the state becomes SHIFT.
  - In SHIFT without a load:
    - if cnt ≠ 0, shift right: PAD <= next bit, cnt <= cnt-1.
    - if cnt = 0, go to IDLE and pulse QUF for one cycle.
  - In IDLE, PAD holds the last emitted bit.
  - PAD_OE <= QEN every edge, independent of the shifter.
  - QRDY = QRT && (state==IDLE || cnt==0). A load at cnt==0 chains back-to-back with no gap bit and no QUF.
  - QLD while QRDY=0 is ignored. The source must hold QLD until it is accepted.

## Timing
- Reset (QRT low) forces the following immediately and asynchronously:
  - PAD = {WIDTH{RESET_VAL}} and PAD_OE = 0 (OUT_REG, OUT_SER).
  - state = IDLE, cnt = 0, QUF = 0, QRDY = 0.
  - QRDY goes to 1 combinationally once QRT rises.
- Reset mid-word discards the remaining bits. No QUF is generated.
- OUT_REG latency: 1 cycle from QDI/QEN to PAD/PAD_OE.
- OUT_SER timing, with the load accepted at edge N:
  - bit k appears on PAD after edge N+k, for k = 0..SER_RATIO-1.
  - The earliest next load is at edge N+SER_RATIO-1.
  - Without a reload there, QUF is high for the cycle following edge N+SER_RATIO.
- PAD_OE in OUT_SER lags QEN by 1 cycle, the same as OUT_REG.

## Structure
- The shared package out_bank_pkg holds:
  - the mode string constants;
  - the FSM state typedef (IDLE, SHIFT);
  - the counter-width localparam helper.
- Sub-module out_ser_lane is one per channel. It contains the SER_RATIO-bit shift register and PAD flop, with load/shift strobes driven by the shared FSM in out_bank_cell.
- Mode selection uses a generate on MODE, so unused logic is not elaborated.

## Test plan
- OUT_BUFF, WIDTH=4: QDI=4'hA, QEN=4'hF, with QRT toggled → PAD=4'hA and PAD_OE=4'hF in the same cycle, unaffected by reset.
- OUT_REG, RESET_VAL=1: hold QRT low → PAD=4'hF, PAD_OE=0. Release, then drive QDI=4'h5 at edge 1 → PAD=4'h5 after edge 1.
- OUT_SER, SER_RATIO=4, WIDTH=2: load QPD=8'b1100_0101 → channel 0 emits 1,0,1,0 and channel 1 emits 0,0,1,1 over 4 cycles. QUF pulses once, 1 cycle after the last bit.
- OUT_SER back-to-back: hold QLD=1 with new words → QRDY high at cnt==0, continuous bit stream with no gap, QUF never asserted.
- OUT_SER: assert QRT low after bit 1 of a word → PAD = RESET_VAL immediately, QRDY=0, no QUF. After release, QRDY=1 and a fresh load starts at bit 0.
- OUT_SER: QLD asserted while QRDY=0 (cnt=2) → word ignored, current word completes unchanged.

Source files
------------

// File: rtl/out_bank_pkg.sv
// Shared definitions for the AP3 output bank: mode names, serialiser FSM
// states and the shared down-counter width.
package out_bank_pkg;

  localparam string MODE_REG  = "OUT_REG";
  localparam string MODE_BUFF = "OUT_BUFF";
  localparam string MODE_SER  = "OUT_SER";

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int cnt_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/out_ser_lane.sv
// One serialiser channel: PAD flop plus the not-yet-emitted bits; 1-cycle load-to-pad,
// strobes come from the shared FSM so the lane never stalls on its own.
module out_ser_lane #(
  parameter int   SER_RATIO = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [SER_RATIO-1:0] word,
  output logic                 pad
);

  // Bit 0 goes straight to the pad on load, so only the upper bits are kept.
  logic [SER_RATIO-2:0] rest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad  <= RESET_VAL;
      rest <= '0;
    end else if (load) begin
      pad  <= word[0];
      rest <= word[SER_RATIO-1:1];
    end else if (shift) begin
      pad  <= rest[0];
      rest <= rest >> 1;
    end
  end

endmodule

// File: rtl/out_bank_cell.sv
// Multi-channel pad output cell: registered (1 cycle), buffered (0 cycles) or
// serialised LSB-first; serial loads use QLD/QRDY, QUF flags a missed reload.
module out_bank_cell
  import out_bank_pkg::*;
#(
  parameter int    WIDTH     = 4,
  parameter string MODE      = "OUT_REG",
  parameter int    SER_RATIO = 4,
  parameter logic  RESET_VAL = 1'b0
) (
  input  logic                       IQC,
  input  logic                       QRT,
  input  logic [WIDTH-1:0]           QDI,
  input  logic [WIDTH-1:0]           QEN,
  input  logic [WIDTH*SER_RATIO-1:0] QPD,
  input  logic                       QLD,
  output logic                       QRDY,
  output logic                       QUF,
  output logic [WIDTH-1:0]           PAD,
  output logic [WIDTH-1:0]           PAD_OE
);

  if (WIDTH < 1) begin : g_bad_width
    $error("out_bank_cell: WIDTH must be >= 1");
  end
  if (SER_RATIO < 2) begin : g_bad_ratio
    $error("out_bank_cell: SER_RATIO must be >= 2");
  end

  if (MODE == MODE_BUFF) begin : g_buff
    logic unused;
    assign unused = ^{IQC, QRT, QPD, QLD};
    assign PAD    = QDI;
    assign PAD_OE = QEN;
    assign QRDY   = 1'b0;
    assign QUF    = 1'b0;

  end else if (MODE == MODE_REG) begin : g_reg
    logic unused;
    assign unused = ^{QPD, QLD};
    assign QRDY   = 1'b0;
    assign QUF    = 1'b0;

    always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
        PAD    <= {WIDTH{RESET_VAL}};
        PAD_OE <= '0;
      end else begin
        PAD    <= QDI;
        PAD_OE <= QEN;
      end
    end

  end else if (MODE == MODE_SER) begin : g_ser
    localparam int             CW      = cnt_width(SER_RATIO);
    localparam logic [CW-1:0] CNT_TOP = CW'(SER_RATIO - 1);

    ser_state_t    state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          shift;
    logic          unused;

    assign unused = ^QDI;
    // Ready on the last bit too, so a waiting word chains with no gap.
    assign QRDY   = QRT && ((state == IDLE) || (cnt == '0));
    assign load   = QLD && QRDY;
    assign shift  = (state == SHIFT) && !load && (cnt != '0);

    always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
        state  <= IDLE;
        cnt    <= '0;
        QUF    <= 1'b0;
        PAD_OE <= '0;
      end else begin
        QUF    <= 1'b0;
        PAD_OE <= QEN;
        if (load) begin
          state <= SHIFT;
          cnt   <= CNT_TOP;
        end else if (state == SHIFT) begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
            QUF   <= 1'b1;
          end
        end
      end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_lane
      out_ser_lane #(
        .SER_RATIO (SER_RATIO),
        .RESET_VAL (RESET_VAL)
      ) u_lane (
        .clk   (IQC),
        .rst_n (QRT),
        .load  (load),
        .shift (shift),
        .word  (QPD[c*SER_RATIO +: SER_RATIO]),
        .pad   (PAD[c])
      );
    end

  end else begin : g_bad_mode
    $error("out_bank_cell: MODE must be OUT_REG, OUT_BUFF or OUT_SER");
  end

endmodule

// File: tb/tb_out_bank_cell.sv
// Bench for out_bank_cell: serialiser instance checked through a per-cycle
// scoreboard fed by a bit-queue model; registered and buffered instances alongside.
module tb_out_bank_cell;

  localparam int   W  = 2;
  localparam int   R  = 4;
  localparam logic RV = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Serialiser instance
  logic [W-1:0]   s_di, s_en;
  logic [W*R-1:0] s_pd;
  logic           s_ld;
  logic [W-1:0]   s_pad, s_oe;
  logic           s_rdy, s_uf;

  out_bank_cell #(.WIDTH(W), .MODE("OUT_SER"), .SER_RATIO(R), .RESET_VAL(RV)) u_ser (
    .IQC(clk), .QRT(rst_n), .QDI(s_di), .QEN(s_en), .QPD(s_pd), .QLD(s_ld),
    .QRDY(s_rdy), .QUF(s_uf), .PAD(s_pad), .PAD_OE(s_oe)
  );

  // Registered and buffered instances share inputs
  logic [3:0]  r_di, r_en;
  logic [15:0] r_pd;
  logic        r_ld;
  logic [3:0]  r_pad, r_oe, b_pad, b_oe;
  logic        r_rdy, r_uf, b_rdy, b_uf;

  out_bank_cell #(.WIDTH(4), .MODE("OUT_REG"), .SER_RATIO(4), .RESET_VAL(1'b1)) u_reg (
    .IQC(clk), .QRT(rst_n), .QDI(r_di), .QEN(r_en), .QPD(r_pd), .QLD(r_ld),
    .QRDY(r_rdy), .QUF(r_uf), .PAD(r_pad), .PAD_OE(r_oe)
  );

  out_bank_cell #(.WIDTH(4), .MODE("OUT_BUFF"), .SER_RATIO(4), .RESET_VAL(1'b0)) u_buf (
    .IQC(clk), .QRT(rst_n), .QDI(r_di), .QEN(r_en), .QPD(r_pd), .QLD(r_ld),
    .QRDY(b_rdy), .QUF(b_uf), .PAD(b_pad), .PAD_OE(b_oe)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes a queue of per-cycle pad vectors.
  typedef struct {
    logic [W-1:0] pad;
    logic [W-1:0] oe;
    logic         rdy;
    logic         uf;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] bitq[$];
  logic [W-1:0] m_pad    = {W{RV}};
  logic         m_active = 1'b0;
  logic         m_acc    = 1'b0;
  logic [3:0]   r_exp_pad = 4'hF;
  logic [3:0]   r_exp_oe  = 4'h0;

  always @(posedge clk) begin
    exp_t         e;
    logic         rdy_b;
    logic [W-1:0] v;
    rdy_b = rst_n && (bitq.size() == 0);
    m_acc = 1'b0;
    e.uf  = 1'b0;
    if (!rst_n) begin
      bitq.delete();
      m_pad    = {W{RV}};
      m_active = 1'b0;
      e.oe     = '0;
    end else begin
      e.oe = s_en;
      if (s_ld && rdy_b) begin
        m_acc = 1'b1;
        bitq.delete();
        for (int k = 0; k < R; k++) begin
          for (int c = 0; c < W; c++) v[c] = s_pd[c*R + k];
          bitq.push_back(v);
        end
        m_pad    = bitq.pop_front();
        m_active = 1'b1;
      end else if (bitq.size() > 0) begin
        m_pad = bitq.pop_front();
      end else if (m_active) begin
        m_active = 1'b0;
        e.uf     = 1'b1;
      end
    end
    e.pad = m_pad;
    e.rdy = rst_n && (bitq.size() == 0);
    sb_q.push_back(e);
    r_exp_pad = rst_n ? r_di : 4'hF;
    r_exp_oe  = rst_n ? r_en : 4'h0;
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("ser_pad", 32'(s_pad), 32'(e.pad));
      chk("ser_oe",  32'(s_oe),  32'(e.oe));
      chk("ser_rdy", 32'(s_rdy), 32'(e.rdy));
      chk("ser_uf",  32'(s_uf),  32'(e.uf));
      chk("reg_pad", 32'(r_pad), 32'(r_exp_pad));
      chk("reg_oe",  32'(r_oe),  32'(r_exp_oe));
      chk("reg_tied", 32'({r_rdy, r_uf}), 32'(0));
      chk("buf_pad", 32'(b_pad), 32'(r_di));
      chk("buf_oe",  32'(b_oe),  32'(r_en));
      chk("buf_tied", 32'({b_rdy, b_uf}), 32'(0));
    end
  end

  task automatic step();
    logic [31:0] rnd;
    @(negedge clk);
    #2;
    rnd  = $urandom;
    r_di = rnd[3:0];
    r_en = rnd[7:4];
    s_en = rnd[9:8];
    s_di = rnd[11:10];
  endtask

  task automatic drive_ser(input int n, input int load_pct);
    logic [31:0] rnd;
    for (int i = 0; i < n; i++) begin
      step();
      if (s_ld && m_acc) s_ld = 1'b0;
      if (!s_ld && ($urandom_range(99) < load_pct)) begin
        rnd  = $urandom;
        s_ld = 1'b1;
        s_pd = rnd[W*R-1:0];
      end
    end
  endtask

  initial begin
    logic [31:0] rnd;
    s_di = '0; s_en = '0; s_pd = '0; s_ld = 1'b0;
    r_di = 4'hA; r_en = 4'hF; r_pd = '0; r_ld = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_ser_pad", 32'(s_pad), 32'({W{RV}}));
    chk("rst_ser_oe",  32'(s_oe),  32'(0));
    chk("rst_ser_rdy", 32'(s_rdy), 32'(0));
    chk("rst_ser_uf",  32'(s_uf),  32'(0));
    chk("rst_reg_pad", 32'(r_pad), 32'(4'hF));
    chk("rst_reg_oe",  32'(r_oe),  32'(0));
    chk("rst_buf_pad", 32'(b_pad), 32'(4'hA));
    chk("rst_buf_oe",  32'(b_oe),  32'(4'hF));

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("release_rdy", 32'(s_rdy), 32'(1));

    // Known word, then let it run out to see the underrun pulse
    step();
    s_ld = 1'b1;
    s_pd = 8'b1100_0101;
    drive_ser(10, 0);

    // Random loads, including attempts while busy
    drive_ser(200, 30);
    drive_ser(8, 0);

    // Back-to-back words with QLD held high
    drive_ser(60, 100);
    drive_ser(8, 0);

    // Reset after bit 1 of a word
    step();
    rnd  = $urandom;
    s_ld = 1'b1;
    s_pd = rnd[W*R-1:0];
    step();
    chk("mid_load_acc", 32'(m_acc), 32'(1));
    s_ld = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pad", 32'(s_pad), 32'({W{RV}}));
    chk("mid_rst_oe",  32'(s_oe),  32'(0));
    chk("mid_rst_rdy", 32'(s_rdy), 32'(0));
    chk("mid_rst_uf",  32'(s_uf),  32'(0));
    chk("mid_rst_reg", 32'(r_pad), 32'(4'hF));
    step();
    step();
    rst_n = 1'b1;
    #1 chk("mid_release_rdy", 32'(s_rdy), 32'(1));

    // Fresh word after reset starts at bit 0
    rnd  = $urandom;
    s_ld = 1'b1;
    s_pd = rnd[W*R-1:0];
    drive_ser(12, 0);
    drive_ser(40, 50);
    drive_ser(8, 0);

    step();
    chk("sb_drain", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
